// File: rtl/edf_deadline_scheduler.sv
// Earliest-deadline-first arbiter. Every queue has a relative deadline (period)
// and a countdown counter. The scheduler offers the pending queue whose counter
// is closest to expiry. It holds that offer until it is accepted, then pauses for
// one cycle so the reloaded counter is visible before the next pick.
module edf_deadline_scheduler #(
  parameter int QUEUE_NUMBER = 4,
  parameter int VALUE_SIZE   = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [QUEUE_NUMBER*VALUE_SIZE-1:0] in_period,
  input  logic                               in_period_load,
  input  logic [QUEUE_NUMBER-1:0]            in_nonempty,
  input  logic                               in_ready,
  output logic                               out_valid,
  output logic [QUEUE_NUMBER-1:0]            out_grant,
  output logic [VALUE_SIZE-1:0]              out_deadline
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SETTLE
  } state_e;

  localparam logic [VALUE_SIZE-1:0] VAL_ONE  = VALUE_SIZE'(1);
  localparam logic [VALUE_SIZE-1:0] VAL_ZERO = '0;

  state_e                  state_q, state_d;
  logic [QUEUE_NUMBER-1:0] grant_q, grant_d;
  logic [VALUE_SIZE-1:0]   deadline_q, deadline_d;

  logic [VALUE_SIZE-1:0]   period_q [QUEUE_NUMBER];
  logic [VALUE_SIZE-1:0]   period_d [QUEUE_NUMBER];
  logic [VALUE_SIZE-1:0]   count_q  [QUEUE_NUMBER];
  logic [VALUE_SIZE-1:0]   count_d  [QUEUE_NUMBER];

  logic                    handshake;
  logic                    sel_found;
  logic [QUEUE_NUMBER-1:0] sel_grant;
  logic [VALUE_SIZE-1:0]   sel_value;

  assign handshake    = (state_q == OFFER) && in_ready;
  assign out_valid    = (state_q == OFFER);
  assign out_grant    = grant_q;
  assign out_deadline = deadline_q;

  // Counter next-state: a period load wins, then the reload of the accepted queue, else saturating countdown
  always_comb begin
    for (int i = 0; i < QUEUE_NUMBER; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = (count_q[i] == VAL_ZERO) ? VAL_ZERO : (count_q[i] - VAL_ONE);
      if (handshake && grant_q[i]) begin
        count_d[i] = period_q[i];
      end
      if (in_period_load) begin
        period_d[i] = in_period[i*VALUE_SIZE +: VALUE_SIZE];
        count_d[i]  = in_period[i*VALUE_SIZE +: VALUE_SIZE];
      end
    end
  end

  // Minimum search over the counter values that will be current when the offer appears; strict compare keeps the lowest index on ties
  always_comb begin
    sel_found = 1'b0;
    sel_grant = '0;
    sel_value = '1;
    for (int i = 0; i < QUEUE_NUMBER; i++) begin
      if (in_nonempty[i] && (!sel_found || (count_d[i] < sel_value))) begin
        sel_found    = 1'b1;
        sel_grant    = '0;
        sel_grant[i] = 1'b1;
        sel_value    = count_d[i];
      end
    end
  end

  // Offer FSM: capture a selection in IDLE, freeze it in OFFER, spend one quiet cycle in SETTLE
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    deadline_d = deadline_q;
    case (state_q)
      IDLE: begin
        if (|in_nonempty) begin
          state_d    = OFFER;
          grant_d    = sel_grant;
          deadline_d = sel_value;
        end
      end
      OFFER: begin
        if (in_ready) begin
          state_d = SETTLE;
          grant_d = '0;
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM and offer registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      deadline_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      deadline_q <= deadline_d;
    end
  end

  // Period and deadline counter registers, all-ones out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < QUEUE_NUMBER; i++) begin
        period_q[i] <= '1;
        count_q[i]  <= '1;
      end
    end else begin
      for (int i = 0; i < QUEUE_NUMBER; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_edf_deadline_scheduler.sv
// Testbench for edf_deadline_scheduler: directed scenarios with fixed expected
// values, plus a reference model that pushes each expected offer to a scoreboard
// queue. The scoreboard compares and retires that offer when it is accepted.
module tb_edf_deadline_scheduler;

  localparam int QN = 4;
  localparam int VS = 16;

  typedef struct {
    logic [QN-1:0] grant;
    logic [VS-1:0] deadline;
  } offer_t;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [QN*VS-1:0]  inPeriod;
  logic              inPeriodLoad;
  logic [QN-1:0]     inNonempty;
  logic              inReady;
  logic              outValid;
  logic [QN-1:0]     outGrant;
  logic [VS-1:0]     outDeadline;

  int vectors = 0;
  int miscompares = 0;

  offer_t expQ[$];
  logic [VS-1:0] mP [QN];
  logic [VS-1:0] mC [QN];
  int mState = 0;
  int mGrant = 0;

  edf_deadline_scheduler #(.QUEUE_NUMBER(QN), .VALUE_SIZE(VS)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .in_period     (inPeriod),
    .in_period_load(inPeriodLoad),
    .in_nonempty   (inNonempty),
    .in_ready      (inReady),
    .out_valid     (outValid),
    .out_grant     (outGrant),
    .out_deadline  (outDeadline)
  );

  // Free-running 10 ns clock
  always #5 aclk = ~aclk;

  // Reference model: counters, periods and offer state evolve from the driven inputs only; each new offer goes onto the scoreboard
  always @(posedge aclk or negedge aresetn) begin
    logic [VS-1:0] nc [QN];
    int best;
    if (!aresetn) begin
      for (int i = 0; i < QN; i++) begin
        mP[i] = 16'hFFFF;
        mC[i] = 16'hFFFF;
      end
      mState = 0;
      mGrant = 0;
      expQ.delete();
    end else begin
      for (int i = 0; i < QN; i++) begin
        if (inPeriodLoad) nc[i] = inPeriod[i*VS +: VS];
        else if (mState == 1 && inReady && mGrant == i) nc[i] = mP[i];
        else if (mC[i] == 0) nc[i] = 0;
        else nc[i] = mC[i] - 16'd1;
        if (inPeriodLoad) mP[i] = inPeriod[i*VS +: VS];
      end
      case (mState)
        0: begin
          if (inNonempty != 0) begin
            offer_t o;
            best = -1;
            for (int i = 0; i < QN; i++)
              if (inNonempty[i] && (best < 0 || nc[i] < nc[best])) best = i;
            o.grant = 4'b0001 << best;
            o.deadline = nc[best];
            expQ.push_back(o);
            mGrant = best;
            mState = 1;
          end
        end
        1: if (inReady) mState = 2;
        default: mState = 0;
      endcase
      for (int i = 0; i < QN; i++) mC[i] = nc[i];
    end
  end

  // Scoreboard: on every falling edge the DUT offer must match the model and the front of the queue; an accepted offer is retired
  always @(negedge aclk) begin
    vectors++;
    if (outValid !== (mState == 1)) begin
      miscompares++;
      $display("[TB] FAIL sb_valid: got %b expected %b at %0t", outValid, (mState == 1), $time);
    end else if (outValid) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_empty: offer grant %b with no expected entry at %0t", outGrant, $time);
      end else if (outGrant !== expQ[0].grant || outDeadline !== expQ[0].deadline) begin
        miscompares++;
        $display("[TB] FAIL sb_offer: got grant %b deadline %0d expected grant %b deadline %0d at %0t",
                 outGrant, outDeadline, expQ[0].grant, expQ[0].deadline, $time);
      end
    end else begin
      vectors++;
      if (outGrant !== '0) begin
        miscompares++;
        $display("[TB] FAIL sb_idle_grant: got %b expected 0000 at %0t", outGrant, $time);
      end
    end
    if (mState == 1 && inReady && aresetn && expQ.size() != 0) void'(expQ.pop_front());
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic goIdle();
    inNonempty = '0;
    inPeriodLoad = 1'b0;
    inReady = 1'b1;
    repeat (4) step();
    inReady = 1'b0;
  endtask

  task automatic expectOffer(input string name, input logic v, input logic [QN-1:0] g, input logic [VS-1:0] d);
    vectors++;
    if (outValid !== v || outGrant !== g || (v && outDeadline !== d)) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid %b grant %b deadline %0d expected valid %b grant %b deadline %0d",
               name, outValid, outGrant, outDeadline, v, g, d);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (outValid !== 1'b0 || outGrant !== '0 || outDeadline !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: got valid %b grant %b deadline %0d expected 0 0000 0", outValid, outGrant, outDeadline);
    end
  endtask

  task automatic test_load_select();
    inPeriod = {16'd20, 16'd30, 16'd10, 16'd40};
    inPeriodLoad = 1'b1;
    step();
    inPeriodLoad = 1'b0;
    inNonempty = 4'b1111;
    step();
    expectOffer("load_select", 1'b1, 4'b0010, 16'd9);
  endtask

  task automatic test_tie();
    inPeriod = {16'd6, 16'd50, 16'd6, 16'd50};
    inPeriodLoad = 1'b1;
    step();
    inPeriodLoad = 1'b0;
    inNonempty = 4'b1010;
    step();
    expectOffer("tie_break", 1'b1, 4'b0010, 16'd5);
  endtask

  task automatic test_hold();
    for (int k = 0; k < 10; k++) begin
      if (k == 3) inNonempty = 4'b1000;
      step();
      expectOffer("hold_stable", 1'b1, 4'b0010, 16'd5);
    end
  endtask

  task automatic test_handshake();
    inPeriod = {16'd20, 16'd30, 16'd10, 16'd40};
    inPeriodLoad = 1'b1;
    step();
    inPeriodLoad = 1'b0;
    inNonempty = 4'b1111;
    step();
    expectOffer("hs_offer", 1'b1, 4'b0010, 16'd9);
    inReady = 1'b1;
    inNonempty = 4'b1101;
    step();
    inReady = 1'b0;
    expectOffer("hs_settle", 1'b0, 4'b0000, 16'd0);
    step();
    expectOffer("hs_idle", 1'b0, 4'b0000, 16'd0);
    step();
    expectOffer("hs_reselect", 1'b1, 4'b1000, 16'd16);
  endtask

  task automatic test_saturate();
    inPeriod = {16'd100, 16'd5, 16'd100, 16'd100};
    inPeriodLoad = 1'b1;
    step();
    inPeriodLoad = 1'b0;
    repeat (20) step();
    inNonempty = 4'b1111;
    step();
    expectOffer("saturate", 1'b1, 4'b0100, 16'd0);
  endtask

  task automatic test_zero_period();
    inPeriod = {16'd50, 16'd50, 16'd50, 16'd0};
    inPeriodLoad = 1'b1;
    step();
    inPeriodLoad = 1'b0;
    inNonempty = 4'b1111;
    step();
    expectOffer("zero_period", 1'b1, 4'b0001, 16'd0);
  endtask

  task automatic test_reset_mid_offer();
    step();
    aresetn = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || outGrant !== '0 || outDeadline !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got valid %b grant %b deadline %0d expected 0 0000 0", outValid, outGrant, outDeadline);
    end
    repeat (2) step();
    aresetn = 1'b1;
    step();
    expectOffer("post_reset", 1'b1, 4'b0001, 16'hFFFE);
  endtask

  task automatic test_back_to_back();
    inReady = 1'b1;
    for (int k = 0; k < 200; k++) begin
      inNonempty = QN'($urandom);
      inPeriodLoad = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < QN; i++) inPeriod[i*VS +: VS] = VS'($urandom_range(0, 40));
      step();
    end
    inPeriodLoad = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    aresetn = 1'b0;
    inPeriod = '0;
    inPeriodLoad = 1'b0;
    inNonempty = '0;
    inReady = 1'b0;
    repeat (3) step();
    test_reset();
    aresetn = 1'b1;
    step();
    test_load_select();
    goIdle();
    test_tie();
    test_hold();
    goIdle();
    test_handshake();
    goIdle();
    test_saturate();
    goIdle();
    test_zero_period();
    test_reset_mid_offer();
    goIdle();
    test_back_to_back();
    goIdle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edf_deadline_scheduler.md
EDF_DEADLINE_SCHEDULER -- requirements
Module: edf_deadline_scheduler

Interface
REQ-001 The block SHALL have parameter QUEUE_NUMBER, default 4, giving the number of request queues arbitrated.
REQ-002 The block SHALL have parameter VALUE_SIZE, default 16, giving the width of periods and deadline counters.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_period, input, QUEUE_NUMBER*VALUE_SIZE bits: per-queue relative deadline; queue i occupies bits [i*VALUE_SIZE +: VALUE_SIZE].
REQ-007 Port in_period_load, input, 1 bit: latches in_period into the period registers and reloads all counters.
REQ-008 Port in_nonempty, input, QUEUE_NUMBER bits: bit i high when queue i holds a pending transaction.
REQ-009 Port in_ready, input, 1 bit: downstream accepts the current offer.
REQ-010 Port out_valid, output, 1 bit: an offer is presented.
REQ-011 Port out_grant, output, QUEUE_NUMBER bits: one-hot selected queue; all-zero when out_valid is low.
REQ-012 Port out_deadline, output, VALUE_SIZE bits: counter value of the selected queue at selection time.

Function
REQ-013 Each queue i SHALL have a period register P[i] and a deadline counter C[i], both VALUE_SIZE bits, unsigned.
REQ-014 Each cycle C[i] SHALL decrement by 1, saturating at 0; no wrap-around.
REQ-015 When in_period_load is high, P[i] <= in_period slice i and C[i] <= in_period slice i for all i; this overrides decrement and handshake reload.
REQ-016 On handshake (out_valid & in_ready), C[g] SHALL reload from P[g] for the granted queue g only; other counters keep decrementing.
REQ-017 Selection SHALL choose, among queues with in_nonempty high, the queue with minimum C[i] (unsigned compare); ties resolve to the lowest index.
REQ-018 The FSM SHALL have states IDLE, OFFER, SETTLE.
REQ-019 IDLE: if any in_nonempty bit is high, register the selection (grant, C value) and go to OFFER; else stay in IDLE.
REQ-020 OFFER: out_valid high; out_grant and out_deadline SHALL be held stable until handshake, regardless of counter or in_nonempty changes.
REQ-021 OFFER with in_ready high: go to SETTLE next cycle; with in_ready low: stay in OFFER.
REQ-022 SETTLE: out_valid low for exactly one cycle, then IDLE; this lets the reload become visible before reselection.
REQ-023 Latency: in_nonempty rising in IDLE SHALL give out_valid high on the next cycle; minimum spacing between consecutive handshakes is 3 cycles.
REQ-024 in_nonempty[g] dropping during OFFER SHALL NOT withdraw the offer.
REQ-025 A period of 0 SHALL hold the counter at 0 and remain selectable.
REQ-026 in_period_load coinciding with a handshake on the same queue SHALL leave C[g] equal to the new in_period value.

Reset
REQ-027 On aresetn low, asynchronously: FSM to IDLE; out_valid=0, out_grant=0, out_deadline=0; all P[i] and C[i] set to all-ones.
REQ-028 Reset asserted mid-OFFER SHALL drop out_valid immediately and discard the offer; no reload occurs.
REQ-029 After aresetn deasserts, the first state change SHALL occur on the first rising aclk edge.

Verification
REQ-030 Load periods {40,10,30,20}, all nonempty -> out_grant=0010, out_deadline=9 one cycle after load.
REQ-031 Counters C1=C3=5, queues 1 and 3 nonempty -> out_grant=0010 (lowest-index tie break).
REQ-032 Hold in_ready low for 10 cycles in OFFER while counters change -> out_grant and out_deadline unchanged throughout.
REQ-033 Handshake on queue 1 with P[1]=10 -> SETTLE for one cycle, C[1]=10 on the cycle after the handshake, then reselection among remaining queues.
REQ-034 Leave a queue unserviced past its period -> C stays at 0 without wrapping, and the queue wins against any nonzero counter.
REQ-035 Assert aresetn low during OFFER -> out_valid=0 with no clock edge; after release, C[i]=all-ones and FSM in IDLE.
